// File: rtl/mod_inverse.sv
// Sequential modular inverter: result = a^-1 mod MOD via binary extended GCD.
// One algorithm step per clock and no multipliers. The start/done handshake
// matches the modular exponentiator: done is high while the FSM sits in FINISH.
module mod_inverse #(
    parameter int          WIDTH = 32,
    parameter int unsigned MOD   = 998244353
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam logic [WIDTH-1:0] MOD_W = WIDTH'(MOD);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        ITER   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] u, v, x1, x2;
    logic [WIDTH-1:0] u_n, v_n, x1_n, x2_n;
    logic [WIDTH-1:0] result_n;
    logic             err_n;

    // x/2 mod MOD: odd x is made even by adding MOD (one extra bit of headroom).
    function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, MOD_W}) : {1'b0, x};
        return s[WIDTH:1];
    endfunction

    // (p - q) mod MOD for p, q already in 0..MOD-1; the wrap of p-q is undone by +MOD.
    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] p,
                                                 input logic [WIDTH-1:0] q);
        return (p >= q) ? (p - q) : (p - q + MOD_W);
    endfunction

    assign done = (state == FINISH);

    // Next-state and datapath: exactly one GCD action per cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_n  = state;
        u_n      = u;
        v_n      = v;
        x1_n     = x1;
        x2_n     = x2;
        result_n = result;
        err_n    = err;
        case (state)
            IDLE: begin
                if (start) begin
                    u_n     = a;
                    v_n     = MOD_W;
                    x1_n    = WIDTH'(1);
                    x2_n    = '0;
                    state_n = REDUCE;
                end
            end
            REDUCE: begin
                if (u >= MOD_W) begin
                    u_n = u - MOD_W;
                end else if (u == '0) begin
                    result_n = '0;
                    err_n    = 1'b1;
                    state_n  = FINISH;
                end else begin
                    state_n = ITER;
                end
            end
            ITER: begin
                if (u == WIDTH'(1)) begin
                    result_n = x1;
                    err_n    = 1'b0;
                    state_n  = FINISH;
                end else if (v == WIDTH'(1)) begin
                    result_n = x2;
                    err_n    = 1'b0;
                    state_n  = FINISH;
                end else if (!u[0]) begin
                    u_n  = u >> 1;
                    x1_n = half_mod(x1);
                end else if (!v[0]) begin
                    v_n  = v >> 1;
                    x2_n = half_mod(x2);
                end else if (u >= v) begin
                    u_n  = u - v;
                    x1_n = sub_mod(x1, x2);
                end else begin
                    v_n  = v - u;
                    x2_n = sub_mod(x2, x1);
                end
            end
            FINISH: begin
                // A held start yields one computation; wait for it to drop.
                if (!start) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state  <= IDLE;
            u      <= '0;
            v      <= '0;
            x1     <= '0;
            x2     <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            u      <= u_n;
            v      <= v_n;
            x1     <= x1_n;
            x2     <= x2_n;
            result <= result_n;
            err    <= err_n;
        end
    end

endmodule

// File: tb/tb_mod_inverse.sv
// Self-checking bench for mod_inverse: directed steps plus random operands,
// expected results queued at drive time and compared when done rises.
module tb_mod_inverse;

    localparam longint unsigned MODL = 64'd998244353;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic        done;
    logic [31:0] result;
    logic        err;

    typedef struct {
        logic [31:0] res;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    mod_inverse #(.WIDTH(32), .MOD(998244353)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .done   (done),
        .result (result),
        .err    (err)
    );

    always #5 clk = ~clk;

    function automatic longint unsigned mod_pow(input longint unsigned b_in,
                                                input longint unsigned e_in);
        longint unsigned r = 1;
        longint unsigned b = b_in % MODL;
        longint unsigned e = e_in;
        while (e != 0) begin
            if (e[0]) r = (r * b) % MODL;
            b = (b * b) % MODL;
            e = e >> 1;
        end
        return r;
    endfunction

    function automatic exp_t model(input logic [31:0] av);
        exp_t            x;
        longint unsigned am = longint'(av) % MODL;
        if (am == 0) begin
            x.res = '0;
            x.err = 1'b1;
        end else begin
            x.res = 32'(mod_pow(am, MODL - 2));
            x.err = 1'b0;
        end
        return x;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One computation: drive, wait (bounded) for done, compare against the queue,
    // optionally hold start in FINISH, then release and confirm done drops.
    task automatic do_op(input logic [31:0] av, input bit drop_early, input int hold,
                         output int lat);
        exp_t e;
        int   glitches;
        @(negedge clk);
        a     = av;
        start = 1'b1;
        sb.push_back(model(av));
        @(negedge clk);
        lat = 1;
        if (drop_early) begin
            start = 1'b0;
            a     = ~av;
        end
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen", done, 1);
        e = sb.pop_front();
        check("result", result, e.res);
        check("err", err, e.err);
        check("latency_le_134", lat <= 134, 1);
        glitches = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (done !== 1'b1 || result !== e.res) glitches++;
        end
        if (hold > 0) check("held_start_single_run", glitches, 0);
        start = 1'b0;
        @(negedge clk);
        check("done_drops", done, 0);
        check("result_kept_idle", result, e.res);
    endtask

    initial begin
        int              lat;
        int              cnt;
        logic [31:0]     av;
        longint unsigned prod;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        repeat (2) @(negedge clk);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_err", err, 0);
        rst = 1'b0;

        // Basic values; a=1 must take exactly three cycles.
        do_op(32'd1, 1'b0, 0, lat);
        check("latency_a1", lat, 3);
        check("inv1_const", result, 32'd1);
        do_op(32'd2, 1'b0, 0, lat);
        check("inv2_const", result, 32'd499122177);
        do_op(32'd3, 1'b1, 0, lat);   // start dropped and a scrambled mid-run
        check("inv3_const", result, 32'd332748118);

        // Boundaries around the modulus.
        do_op(32'd998244352, 1'b0, 0, lat);
        check("inv_mod_m1", result, 32'd998244352);
        do_op(32'd998244355, 1'b0, 0, lat);
        check("inv_mod_p2", result, 32'd499122177);
        do_op(32'd998244353, 1'b0, 0, lat);
        check("err_mod", err, 1);
        do_op(32'd0, 1'b0, 0, lat);
        check("err_zero", err, 1);
        do_op(32'd3992977412, 1'b0, 0, lat);
        check("err_4mod", err, 1);
        do_op(32'hFFFF_FFFF, 1'b0, 0, lat);
        prod = (64'd301989883 * longint'(result)) % MODL;
        check("inv_allones_product", prod, 1);

        // Random operands, checked by the queue model and by the product identity.
        for (int i = 0; i < 500; i++) begin
            av = $urandom;
            do_op(av, 1'b0, 0, lat);
            if ((longint'(av) % MODL) != 0) begin
                prod = ((longint'(av) % MODL) * longint'(result)) % MODL;
                check("rand_product", prod, 1);
            end
        end

        // Start held high for 200 cycles: one computation, done stays up.
        do_op(32'd2, 1'b0, 200, lat);
        do_op(32'd3, 1'b0, 0, lat);

        // Reset mid-ITER aborts; no done until a fresh start.
        @(negedge clk);
        a     = 32'd12345;
        start = 1'b1;
        repeat (10) @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_err", err, 0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("no_done_after_abort", cnt, 0);
        do_op(32'd12345, 1'b0, 0, lat);
        prod = (64'd12345 * longint'(result)) % MODL;
        check("restart_product", prod, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
